scope_window_accum: RTL and testbench
=====================================

# scope_window_accum

Downstream consumer of the threshold-adjust stage's 8-bit adjusted value. Collects a fixed window of adjusted samples over a valid/ready handshake and emits one result per window: the window sum, the window maximum and the sample count. A flush input closes a partial window early. Decouples the combinational adjust stage from the slower result consumer.

## Interface
Parameters:
- DATA_W, 8, width of each adjusted sample
- WINDOW, 4, samples per window; power of two, 2..16
- Derived localparams:
  - CNT_W = $clog2(WINDOW)+1
  - SUM_W = DATA_W + $clog2(WINDOW)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  adjusted sample from the upstream adjust stage
- flush  in  1  close the current partial window (level, sampled each cycle)
- out_valid  out  1  result held on out_*
- out_ready  in  1  consumer accepts the result
- out_sum  out  SUM_W  sum of the samples in the window
- out_max  out  DATA_W  largest sample in the window (unsigned)
- out_count  out  CNT_W  number of samples in the window (1..WINDOW)

## Operation
- Two-state FSM: ACCUM, HOLD. Reset state is ACCUM.
- Reset values:
  - in_ready=1, out_valid=0
  - out_sum=0, out_max=0, out_count=0
  - internal acc_sum, acc_max and cnt = 0
- ACCUM: in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On accept: acc_sum += in_data, acc_max = max(acc_max, in_data), cnt += 1.
- ACCUM -> HOLD, when either:
  - an accept makes cnt reach WINDOW; or
  - flush=1 and (cnt>0 or an accept occurs in the same cycle).
- On the ACCUM -> HOLD transition:
  - out_sum, out_max and out_count are loaded with the updated values, including any same-cycle sample.
  - The accumulators clear.
- flush=1 with cnt=0 and no accept: ignored, no empty result is ever emitted.
- HOLD: in_ready=0, out_valid=1, out_* stable. flush is ignored.
- HOLD -> ACCUM when out_ready=1. out_* keep their last values; only out_valid drops.
- Arithmetic:
  - All values are unsigned.
  - SUM_W is exact for a full window (WINDOW × (2^DATA_W−1)), so there is no overflow and no saturation.
- Asynchronous reset at any point aborts the current window and returns every register to its reset value. Partial data is discarded.

## Timing
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready to them.
- No combinational path from in_data to any output.
- Latency: out_valid rises the cycle after the accept that completes the window, or after the flush cycle.
- Throughput: WINDOW accepts plus at least 1 HOLD cycle per result. When out_ready is held high, a full window costs WINDOW+1 cycles.
- The first accept of the next window can occur the cycle after the out handshake.
- Upstream must hold in_valid and in_data stable until accepted. The consumer may assert out_ready at any time.

## Structure
- Shared package scope_pkg holds:
  - typedef enum logic {ACCUM, HOLD} accum_state_e
  - default DATA_W and WINDOW localparams
- Single module with no sub-module. FSM, accumulators and output registers fit in one always_ff plus a small always_comb for next-state.
- Elaboration-time assertion that WINDOW is a power of two in 2..16.

## Test plan
- Full window, WINDOW=4: adjusted samples 30, 50, 190, 20 with out_ready=1.
  - out_valid rises one cycle after the 4th accept.
  - out_sum=290, out_max=190, out_count=4.
- Backpressure: out_ready=0 for 5 cycles after a result.
  - out_valid stays 1, out_* stable, in_ready=0 throughout.
  - Accepts resume the cycle after out_ready=1.
- Partial flush: accept 100, 40, then flush=1 with no accept.
  - Result: out_sum=140, out_max=100, out_count=2.
- Flush with accept: flush=1 together with the accept of 7 on an empty window.
  - Result: out_sum=7, out_max=7, out_count=1.
- Flush on empty: flush=1 with cnt=0 and in_valid=0.
  - No out_valid; state stays ACCUM.
- Extremes and reset:
  - Four samples of 255 gives out_sum=1020, out_max=255.
  - Reset asserted after 2 accepts: every output returns to its reset value.
  - Next 4 samples of 1 give out_sum=4 (no residue from the aborted window).

Source files
------------

// File: rtl/scope_window_accum_pkg.sv
// Shared types and default sizing for the scope window accumulator.
package scope_pkg;

  // ACCUM collects samples; HOLD presents a finished window result.
  typedef enum logic {ACCUM, HOLD} accum_state_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_WINDOW = 4;

endpackage : scope_pkg

// File: rtl/scope_window_accum.sv
// Window accumulator: gathers WINDOW adjusted samples (or fewer on flush)
// and presents sum, max and count until the consumer takes the result.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ACCUM | accepting samples, in_ready=1, accumulators update
//   HOLD  | result held on out_*, out_valid=1, waits for out_ready
module scope_window_accum
  import scope_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int WINDOW = DEFAULT_WINDOW,
  localparam int CNT_W = $clog2(WINDOW) + 1,
  localparam int SUM_W = DATA_W + $clog2(WINDOW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_count
);

  if (WINDOW < 2 || WINDOW > 16 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $error("scope_window_accum: WINDOW must be a power of two in 2..16");
  end

  accum_state_e      state_q, state_d;
  logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
  logic [DATA_W-1:0] acc_max_q, acc_max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic              accept;
  logic              close_win;
  logic [SUM_W-1:0]  sum_upd;
  logic [DATA_W-1:0] max_upd;
  logic [CNT_W-1:0]  cnt_upd;

  // Handshake flags come straight from the state register.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_count = out_count_q;

  // Next-state: fold in any same-cycle sample, then decide whether the window closes.
  always_comb begin
    accept    = in_valid && (state_q == ACCUM);
    sum_upd   = accept ? (acc_sum_q + SUM_W'(in_data)) : acc_sum_q;
    max_upd   = (accept && (in_data > acc_max_q)) ? in_data : acc_max_q;
    cnt_upd   = accept ? (cnt_q + CNT_W'(1)) : cnt_q;
    // cnt_upd is nonzero exactly when the window holds data or gains a sample now,
    // so an empty flush never produces a result.
    close_win = (state_q == ACCUM) &&
                ((accept && (cnt_upd == CNT_W'(WINDOW))) ||
                 (flush && (cnt_upd != '0)));

    state_d     = state_q;
    acc_sum_d   = acc_sum_q;
    acc_max_d   = acc_max_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_count_d = out_count_q;

    case (state_q)
      ACCUM: begin
        if (close_win) begin
          state_d     = HOLD;
          out_sum_d   = sum_upd;
          out_max_d   = max_upd;
          out_count_d = cnt_upd;
          acc_sum_d   = '0;
          acc_max_d   = '0;
          cnt_d       = '0;
        end else begin
          acc_sum_d = sum_upd;
          acc_max_d = max_upd;
          cnt_d     = cnt_upd;
        end
      end
      HOLD: begin
        // out_* keep their values after the handshake; only out_valid drops.
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, accumulator and result registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_count_q <= out_count_d;
    end
  end

endmodule : scope_window_accum

// File: tb/tb_scope_window_accum.sv
// Bench for scope_window_accum: directed test-plan steps followed by random
// traffic, checked against a queue-based window model.
module tb_scope_window_accum;

  localparam int DW  = 8;
  localparam int WIN = 4;
  localparam int CW  = $clog2(WIN) + 1;
  localparam int SW  = DW + $clog2(WIN);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_max;
  logic [CW-1:0] out_count;

  scope_window_accum #(.DATA_W(DW), .WINDOW(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_max   (out_max),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // Model: samples of the open window, plus the last published result.
  int unsigned win_q[$];
  bit          exp_hold;
  int unsigned exp_sum, exp_max, exp_cnt;
  bit          last_acc;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!exp_hold));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_hold));
    chk({tag, ".out_sum"},   32'(out_sum),   exp_sum);
    chk({tag, ".out_max"},   32'(out_max),   exp_max);
    chk({tag, ".out_count"}, 32'(out_count), exp_cnt);
  endtask

  task automatic model_reset();
    win_q.delete();
    exp_hold = 1'b0;
    exp_sum  = 0;
    exp_max  = 0;
    exp_cnt  = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic cycle(input bit v, input int unsigned d, input bit f, input bit r, input string tag);
    in_valid  = v;
    in_data   = d[DW-1:0];
    flush     = f;
    out_ready = r;
    last_acc  = 1'b0;
    if (!exp_hold) begin
      if (v) begin
        win_q.push_back(d & 32'hFF);
        last_acc = 1'b1;
      end
      if ((v && win_q.size() == WIN) || (f && win_q.size() > 0)) begin
        exp_sum = 0;
        exp_max = 0;
        foreach (win_q[i]) begin
          exp_sum += win_q[i];
          if (win_q[i] > exp_max) exp_max = win_q[i];
        end
        exp_cnt  = win_q.size();
        win_q.delete();
        exp_hold = 1'b1;
      end
    end else if (r) begin
      exp_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit          rv;
    int unsigned rd;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full window 30,50,190,20
    cycle(1, 30, 0, 1, "full.a0");
    cycle(1, 50, 0, 1, "full.a1");
    cycle(1, 190, 0, 1, "full.a2");
    cycle(1, 20, 0, 1, "full.a3");
    chk("full.sum", 32'(out_sum), 290);
    chk("full.max", 32'(out_max), 190);
    chk("full.cnt", 32'(out_count), 4);
    cycle(0, 0, 0, 1, "full.release");

    // Backpressure for 5 cycles, upstream waiting with 9
    cycle(1, 1, 0, 0, "bp.a0");
    cycle(1, 2, 0, 0, "bp.a1");
    cycle(1, 3, 0, 0, "bp.a2");
    cycle(1, 4, 0, 0, "bp.a3");
    for (int i = 0; i < 5; i++) cycle(1, 9, 0, 0, "bp.stall");
    chk("bp.sum", 32'(out_sum), 10);
    cycle(1, 9, 0, 1, "bp.release");
    cycle(1, 9, 0, 0, "bp.resume");
    chk("bp.resume_taken", 32'(win_q.size()), 1);
    cycle(0, 0, 1, 0, "bp.flush9");
    chk("bp.flush9_sum", 32'(out_sum), 9);
    cycle(0, 0, 0, 1, "bp.flush9_rel");

    // Partial flush
    cycle(1, 100, 0, 1, "pf.a0");
    cycle(1, 40, 0, 1, "pf.a1");
    cycle(0, 0, 1, 1, "pf.flush");
    chk("pf.sum", 32'(out_sum), 140);
    chk("pf.max", 32'(out_max), 100);
    chk("pf.cnt", 32'(out_count), 2);
    cycle(0, 0, 0, 1, "pf.release");

    // Flush together with an accept on an empty window
    cycle(1, 7, 1, 1, "fa.flush");
    chk("fa.sum", 32'(out_sum), 7);
    chk("fa.max", 32'(out_max), 7);
    chk("fa.cnt", 32'(out_count), 1);
    cycle(0, 0, 1, 1, "fa.release_flush_ignored");

    // Flush on an empty window
    cycle(0, 0, 1, 1, "fe.flush");
    chk("fe.no_valid", 32'(out_valid), 0);
    chk("fe.ready", 32'(in_ready), 1);

    // Extremes
    for (int i = 0; i < 4; i++) cycle(1, 255, 0, 0, "ext.a");
    chk("ext.sum", 32'(out_sum), 1020);
    chk("ext.max", 32'(out_max), 255);
    cycle(0, 0, 0, 1, "ext.release");

    // Asynchronous reset mid-window
    cycle(1, 5, 0, 1, "rst.a0");
    cycle(1, 6, 0, 1, "rst.a1");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, "rst.after");
    chk("rst.after_sum", 32'(out_sum), 4);
    chk("rst.after_cnt", 32'(out_count), 4);
    cycle(0, 0, 0, 1, "rst.release");

    // Random traffic; upstream holds a pending sample until it is accepted
    rv = 1'b0;
    rd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(rv && !last_acc)) begin
        rv = ($urandom_range(0, 9) < 7);
        rd = $urandom_range(0, 255);
      end
      cycle(rv, rd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_scope_window_accum
